// File: rtl/pcm_tx_arbiter.sv
// Two-channel byte FIFO + round-robin burst scheduler feeding one shared UART transmitter.
// Optional channel tag bytes are enabled by defining PCM_TX_TAG_EN.
module pcm_tx_arbiter #(
  parameter int         FIFO_AW   = 4,
  parameter int         MAX_BURST = 8,
  parameter logic [7:0] TAG_BASE  = 8'hF0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] a_data,
  input  logic       a_en,
  input  logic [7:0] b_data,
  input  logic       b_en,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy,
  output logic       grant,
  output logic [1:0] ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);

  logic [7:0]         mem  [2][DEPTH];
  logic [FIFO_AW-1:0] wptr [2];
  logic [FIFO_AW-1:0] rptr [2];
  logic [FIFO_AW:0]   cnt  [2];
  logic [7:0]         din  [2];
  logic [1:0]         in_en, full, nempty, push, pop;

  logic [1:0] state;
  logic       cur_ch, cur_tag;
  logic [7:0] burst;
  logic       sel_ok, sel_ch, sel_rst, need_tag;
  logic [7:0] sel_head;

  assign in_en  = {b_en, a_en};
  assign din[0] = a_data;
  assign din[1] = b_data;

  // The transmit strobe is simply the ISSUE state, so an async reset drops it at once.
  assign tx_en = (state == S_ISSUE);

  always_comb begin
    full   = '0;
    nempty = '0;
    push   = '0;
    pop    = '0;
    for (int ch = 0; ch < 2; ch++) begin
      full[ch]   = (cnt[ch] == FULL_CNT);
      nempty[ch] = (cnt[ch] != '0);
      push[ch]   = in_en[ch] && !full[ch];
      pop[ch]    = (state == S_ISSUE) && !cur_tag && (cur_ch == 1'(ch));
    end
  end

  // NOTE: FIFO storage has no reset; contents are only observable through the
  // reset pointers and counts, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (push[ch]) mem[ch][wptr[ch]] <= din[ch];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        wptr[ch] <= '0;
        rptr[ch] <= '0;
        cnt[ch]  <= '0;
      end
      ovf <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (push[ch]) wptr[ch] <= wptr[ch] + 1'b1;
        if (pop[ch])  rptr[ch] <= rptr[ch] + 1'b1;
        if (push[ch] && !pop[ch])      cnt[ch] <= cnt[ch] + 1'b1;
        else if (!push[ch] && pop[ch]) cnt[ch] <= cnt[ch] - 1'b1;
        // A pop in the same cycle never rescues a strobe that arrives while full.
        if (in_en[ch] && full[ch]) ovf[ch] <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    sel_ok  = 1'b0;
    sel_ch  = grant;
    sel_rst = 1'b0;
    if (nempty[grant] && (burst < BURST_MAX)) begin
      sel_ok = 1'b1;
    end else if (nempty[~grant]) begin
      sel_ok  = 1'b1;
      sel_ch  = ~grant;
      sel_rst = 1'b1;
    end else if (nempty[grant]) begin
      sel_ok  = 1'b1;
      sel_rst = 1'b1;
    end
  end

  assign sel_head = mem[sel_ch][rptr[sel_ch]];

`ifdef PCM_TX_TAG_EN
  logic tag_sent;

  // grant tracks the channel of the last issued byte, tags included.
  assign need_tag = !tag_sent || (sel_ch != grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        tag_sent <= 1'b0;
    else if ((state == S_IDLE) && sel_ok && need_tag)    tag_sent <= 1'b1;
  end
`else
  assign need_tag = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cur_ch  <= 1'b0;
      cur_tag <= 1'b0;
      burst   <= 8'd0;
      grant   <= 1'b1;
      tx_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_ok) begin
            state   <= S_ISSUE;
            cur_ch  <= sel_ch;
            cur_tag <= need_tag;
            grant   <= sel_ch;
            tx_data <= need_tag ? (TAG_BASE | {7'b0, sel_ch}) : sel_head;
            if (sel_rst) burst <= 8'd0;
          end
        end
        S_ISSUE: begin
          state <= S_HOLD;
          if (!cur_tag && (burst != 8'hFF)) burst <= burst + 8'd1;
        end
        // One cycle of grace while the UART raises its busy flag.
        S_HOLD: state <= S_WAIT;
        default: if (!tx_busy) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_tx_arbiter.sv
// Directed self-checking bench for pcm_tx_arbiter: a depth-16 instance and a depth-4
// instance share stimulus; each has its own simple UART busy model.
module tb_pcm_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_en = 1'b0, b_en = 1'b0;
  logic       force_busy = 1'b0;

  logic [7:0] tx_data, s_tx_data;
  logic       tx_en, s_tx_en, grant, s_grant, tx_busy, s_tx_busy;
  logic [1:0] ovf, s_ovf;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, s_cyc = 0;
  int busy_len = 10, bcnt = 0, s_bcnt = 0, busy_viol = 0;

  logic [7:0] q_data[$], sq_data[$];
  logic       q_grant[$];
  int         q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy   = force_busy || (bcnt != 0);
  assign s_tx_busy = force_busy || (s_bcnt != 0);

  pcm_tx_arbiter #(.FIFO_AW(4), .MAX_BURST(8), .TAG_BASE(8'hF0)) u_dut (
    .clk(clk), .reset_n(reset_n), .a_data(a_data), .a_en(a_en), .b_data(b_data), .b_en(b_en),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy), .grant(grant), .ovf(ovf));

  pcm_tx_arbiter #(.FIFO_AW(2), .MAX_BURST(8), .TAG_BASE(8'hF0)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .a_data(a_data), .a_en(a_en), .b_data(b_data), .b_en(b_en),
    .tx_data(s_tx_data), .tx_en(s_tx_en), .tx_busy(s_tx_busy), .grant(s_grant), .ovf(s_ovf));

  // UART model and output monitor: busy rises in the strobe cycle, lasts busy_len cycles.
  always @(negedge clk) begin
    if (tx_en) begin
      if (bcnt != 0 || force_busy) busy_viol++;
      q_data.push_back(tx_data);
      q_grant.push_back(grant);
      q_cyc.push_back(cyc);
      bcnt = busy_len;
    end else if (bcnt > 0) bcnt--;
    if (s_tx_en) begin
      sq_data.push_back(s_tx_data);
      s_bcnt = busy_len;
    end else if (s_bcnt > 0) s_bcnt--;
  end

  typedef struct {
    logic       a_en;
    logic [7:0] a_data;
    logic       b_en;
    logic [7:0] b_data;
    int         n_exp;
    logic [7:0] d0;
    logic       g0;
    logic [7:0] d1;
    logic       g1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm, input int idx, input logic [7:0] d);
    if (idx < q_data.size()) check(nm, q_data[idx], d);
    else check({nm, " missing"}, q_data.size(), idx + 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_en = 1'b0;
    b_en = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bcnt = 0;
    s_bcnt = 0;
    busy_viol = 0;
    q_data.delete(); q_grant.delete(); q_cyc.delete(); sq_data.delete();
    reset_n = 1'b1;
  endtask

  task automatic strobe(input logic ae, input logic [7:0] ad, input logic be, input logic [7:0] bd);
    @(posedge clk);
    #1;
    a_en = ae; a_data = ad; b_en = be; b_data = bd;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1, 8'hA5, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 8'hFF, 2, 8'hFF, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1, 8'hFF, 1'b0, 8'h00, 1'b0};

    do_reset();
    check("reset tx_data", tx_data, 8'h00);
    check("reset tx_en", tx_en, 1'b0);
    check("reset grant", grant, 1'b1);
    check("reset ovf", ovf, 2'b00);

`ifdef PCM_TX_TAG_EN
    busy_len = 10;
    strobe(1'b0, 8'h00, 1'b1, 8'h5B);
    repeat (40) @(posedge clk);
    strobe(1'b1, 8'hA1, 1'b0, 8'h00);
    repeat (40) @(posedge clk);
    strobe(1'b1, 8'hA2, 1'b0, 8'h00);
    repeat (40) @(posedge clk);
    #1;
    check("tag count", q_data.size(), 5);
    check_q("tag 0", 0, 8'hF1);
    check_q("tag 1", 1, 8'h5B);
    check_q("tag 2", 2, 8'hF0);
    check_q("tag 3", 3, 8'hA1);
    check_q("tag 4", 4, 8'hA2);
`else
    // Single-shot vectors from a fresh reset: latency, data, grant, pulse count.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      busy_len = 10;
      strobe(vecs[v].a_en, vecs[v].a_data, vecs[v].b_en, vecs[v].b_data);
      repeat (60) @(posedge clk);
      #1;
      check($sformatf("vec%0d count", v), q_data.size(), vecs[v].n_exp);
      if (q_data.size() > 0) begin
        check($sformatf("vec%0d latency", v), q_cyc[0] - s_cyc, 2);
        check($sformatf("vec%0d grant0", v), q_grant[0], vecs[v].g0);
      end
      check_q($sformatf("vec%0d data0", v), 0, vecs[v].d0);
      if (vecs[v].n_exp > 1) begin
        check_q($sformatf("vec%0d data1", v), 1, vecs[v].d1);
        if (q_grant.size() > 1) check($sformatf("vec%0d grant1", v), q_grant[1], vecs[v].g1);
      end
    end

    // Busy handshake with a full-length character time.
    do_reset();
    busy_len = 889;
    for (int i = 0; i < 5; i++) strobe(1'b1, 8'(8'h60 + i), 1'b0, 8'h00);
    wait_pulses(5, 5000);
    check("busy count", q_data.size(), 5);
    for (int i = 0; i < 5; i++) check_q($sformatf("busy data%0d", i), i, 8'(8'h60 + i));
    for (int i = 1; i < 5 && i < q_cyc.size(); i++)
      check($sformatf("busy spacing%0d", i), (q_cyc[i] - q_cyc[i-1]) >= 889, 1'b1);
    check("busy violations", busy_viol, 0);

    // Fairness: A x12 then B x3 queued -> A x8, B x3, A x4.
    do_reset();
    busy_len = 10;
    for (int i = 0; i < 12; i++) strobe(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
    for (int i = 0; i < 3; i++)  strobe(1'b0, 8'h00, 1'b1, 8'(8'h20 + i));
    wait_pulses(15, 1000);
    repeat (30) @(posedge clk);
    #1;
    check("fair count", q_data.size(), 15);
    for (int i = 0; i < 8; i++) check_q($sformatf("fair A%0d", i), i, 8'(8'h10 + i));
    for (int i = 0; i < 3; i++) check_q($sformatf("fair B%0d", i), 8 + i, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) check_q($sformatf("fair A%0d", 8 + i), 11 + i, 8'(8'h18 + i));
    if (q_grant.size() > 8) check("fair grant B", q_grant[8], 1'b1);

    // Overflow on the depth-4 instance with the UART held busy.
    do_reset();
    busy_len = 10;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) strobe(1'b0, 8'h00, 1'b1, 8'(8'h50 + i));
    repeat (10) @(posedge clk);
    #1;
    check("ovf in-flight count", sq_data.size(), 1);
    check("ovf flag", s_ovf, 2'b10);
    force_busy = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("ovf drained count", sq_data.size(), 5);
    for (int i = 0; i < 5 && i < sq_data.size(); i++)
      check($sformatf("ovf data%0d", i), sq_data[i], 8'(8'h50 + i));
    check("ovf sticky", s_ovf, 2'b10);

    // Reset asserted while waiting on the UART with bytes queued.
    do_reset();
    busy_len = 889;
    for (int i = 0; i < 6; i++) strobe(1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("pre-reset grant", grant, 1'b0);
    check("pre-reset small ovf", s_ovf, 2'b01);
    reset_n = 1'b0;
    #1;
    check("mid-reset tx_en", tx_en, 1'b0);
    check("mid-reset tx_data", tx_data, 8'h00);
    check("mid-reset grant", grant, 1'b1);
    check("mid-reset small ovf", s_ovf, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    busy_len = 10;
    q_data.delete(); q_grant.delete(); q_cyc.delete(); sq_data.delete();
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("post-reset silent", q_data.size(), 0);
    check("post-reset small silent", sq_data.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_tx_arbiter.md
# pcm_tx_arbiter

Buffers and schedules decoded bytes from the two PCM NRZ decoder cores (high and low bit rate) onto the single shared UART transmitter. Replaces the combinational priority mux between decoders and UART: each decoder gets its own byte FIFO, and a round-robin burst scheduler issues one byte at a time, honouring the transmitter's busy flag so no byte is lost while a character is in flight. Sits between the two decoder cores and `uart_tx`, all in the `pcm_clk` domain.

## Interface
- `FIFO_AW`, 4: FIFO address width per channel; depth = 2^FIFO_AW bytes.
- `MAX_BURST`, 8: max consecutive bytes from one channel while the other channel has data waiting (1..255).
- `TAG_BASE`, 8'hF0: channel tag byte base; tag = TAG_BASE | {7'b0, ch} (only with TX_TAG_EN).
- `clk`  in  1  PCM clock (10.24 MHz).
- `reset_n`  in  1  asynchronous active-low reset.
- `a_data`  in  8  channel 0 (HBR) byte.
- `a_en`  in  1  channel 0 byte strobe, one cycle per byte.
- `b_data`  in  8  channel 1 (LBR) byte.
- `b_en`  in  1  channel 1 byte strobe.
- `tx_data`  out  8  byte to UART, valid while `tx_en` high.
- `tx_en`  out  1  one-cycle transmit strobe to UART.
- `tx_busy`  in  1  UART busy.
- `grant`  out  1  channel of the byte most recently issued.
- `ovf`  out  2  sticky per-channel overflow flags ([0]=A, [1]=B).

## Operation
- Reset values: `tx_data`=0, `tx_en`=0, `grant`=1, `ovf`=0; FIFOs empty, burst count 0, FSM in IDLE, tag-sent flag cleared.
- FIFOs: write on strobe when count < depth. Strobe while full: byte dropped, `ovf[ch]` set until reset; a pop in the same cycle does not rescue it. Push and pop in the same cycle on a non-full FIFO: count unchanged. Pointers wrap modulo depth; count is FIFO_AW+1 bits.
- FSM states: IDLE, ISSUE, HOLD, WAIT.
  - IDLE: choose channel c: if FIFO[grant] non-empty and burst < MAX_BURST, c=grant; else if FIFO[~grant] non-empty, c=~grant, burst=0; else if FIFO[grant] non-empty, c=grant, burst=0; else stay. On a choice go to ISSUE.
  - ISSUE: pop FIFO[c], drive `tx_data`=head, `tx_en`=1 for exactly one cycle, `grant`=c, burst+=1 (saturating at 255); go to HOLD.
  - HOLD: one cycle, `tx_busy` ignored (covers UART busy-assertion latency); go to WAIT.
  - WAIT: stay while `tx_busy`=1; when `tx_busy`=0 go to IDLE.
- `tx_en` is never asserted outside ISSUE; `tx_data` holds its last value otherwise.
- Both strobes in the same cycle: both written, no loss.

## Timing
- Byte strobed in cycle N into an empty FIFO, FSM in IDLE, UART idle: `tx_en` high in cycle N+2.
- Minimum spacing between `tx_en` pulses: 4 cycles (ISSUE, HOLD, WAIT with busy low, IDLE).
- Worst-case wait for a non-empty channel: MAX_BURST characters of the other channel.
- At 115200 baud (~889 cycles/char) aggregate decoder rate 52.8 kbps < 92 kbps UART payload; FIFOs only absorb burst collisions.
- Reset asserted mid-transfer: all state cleared asynchronously, `tx_en` drops immediately; FIFO contents discarded.

## Configuration
- `PCM_TX_TAG_EN` defined: before the first byte after reset, and whenever c differs from the channel of the previously issued byte, FSM emits tag byte TAG_BASE|c through an extra ISSUE/HOLD/WAIT pass (no pop, burst unchanged), then issues the data byte. Tag counts toward spacing, not burst.
- Undefined: no tag bytes; stream is raw interleaved bytes.

## Test plan
- Single byte: `a_data`=8'h3C strobed at cycle 10, `tx_busy`=0 -> `tx_en`=1 with `tx_data`=8'h3C at cycle 12, `grant`=0, one pulse only.
- Busy handshake: model UART with busy high 889 cycles after each `tx_en`; push 5 bytes on A -> 5 pulses, in order, each ≥889 cycles apart, none during busy.
- Fairness: preload A with 12 bytes and B with 3, MAX_BURST=8 -> order A×8, B×3, A×4.
- Overflow: FIFO_AW=2, hold `tx_busy`=1, strobe B 6 times -> 4 bytes stored, `ovf`=2'b10, stored bytes later sent in order; `ovf` stays set until `reset_n` low.
- Tags (PCM_TX_TAG_EN): one byte on B then one on A -> stream 8'hF1, B byte, 8'hF0, A byte; second consecutive A byte gets no tag.
- Reset mid-operation: assert `reset_n`=0 during WAIT with 3 bytes queued -> `tx_en`=0, `ovf`=0, `grant`=1 immediately; after release no bytes emitted until new strobes.
